// File: rtl/ram_copy_engine.sv
// Block-copy initiator for a single-port RAM with a one-cycle registered read.
// Alternates RD/WR per byte in ascending order, so overlapping regions get forward-copy semantics.
module ram_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q, dst_q, idx;
    logic [LEN_W-1:0]  len_q;
    logic              last_byte;

    assign last_byte = (count + LEN_W'(1)) == len_q;

    // NOTE: every register here uses <= so all reads see pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    src_q <= src_addr;
                    dst_q <= dst_addr;
                    len_q <= len;
                    idx   <= '0;
                    count <= '0;
                end
                WR: begin
                    // idx is ADDR_W wide, so it silently wraps after a full 256-byte copy.
                    idx   <= idx + ADDR_W'(1);
                    count <= count + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: default assignment first in every combinational block, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len == '0) ? DONE : RD;
            RD:   state_nxt = WR;
            WR:   state_nxt = last_byte ? DONE : RD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address sums are ADDR_W wide, giving modulo-2^ADDR_W wrap for free.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        case (state)
            RD: begin
                MemRead = 1'b1;
                addr    = src_q + idx;
            end
            WR: begin
                MemWrite = 1'b1;
                addr     = dst_q + idx;
                wdata    = rdata;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
